// File: rtl/axi_pkg.sv
// AXI5 atomic-operation encodings (subset of the shared AXI package used by the bank adapters).
package axi_pkg;

  typedef logic [5:0] atop_t;

  localparam logic [1:0] ATOP_NONE        = 2'b00;
  localparam logic [1:0] ATOP_ATOMICSTORE = 2'b01;
  localparam logic [1:0] ATOP_ATOMICLOAD  = 2'b10;
  localparam logic [5:0] ATOP_ATOMICSWAP  = 6'b110000;
  localparam logic [5:0] ATOP_ATOMICCMP   = 6'b110001;

  localparam logic [2:0] ATOP_ADD  = 3'b000;
  localparam logic [2:0] ATOP_CLR  = 3'b001;
  localparam logic [2:0] ATOP_EOR  = 3'b010;
  localparam logic [2:0] ATOP_SET  = 3'b011;
  localparam logic [2:0] ATOP_SMAX = 3'b100;
  localparam logic [2:0] ATOP_SMIN = 3'b101;
  localparam logic [2:0] ATOP_UMAX = 3'b110;
  localparam logic [2:0] ATOP_UMIN = 3'b111;

endpackage

// File: rtl/mem_bank_atomic_adapter_amo_alu.sv
// Combinational AMO ALU: (old, operand, strobe, atop) -> value to write back.
// Disabled byte lanes keep the old memory value.
module mem_amo_alu
  import axi_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic [DataWidth-1:0] old_i,
  input  logic [DataWidth-1:0] op_i,
  input  logic [StrbWidth-1:0] strb_i,
  input  atop_t                atop_i,
  output logic [DataWidth-1:0] result_o
);

  logic [DataWidth-1:0] res;

  always_comb begin
    res = old_i;
    if (atop_i == ATOP_ATOMICSWAP) begin
      res = op_i;
    end else begin
      case (atop_i[2:0])
        ATOP_ADD:  res = old_i + op_i;
        ATOP_CLR:  res = old_i & ~op_i;
        ATOP_EOR:  res = old_i ^ op_i;
        ATOP_SET:  res = old_i | op_i;
        ATOP_SMAX: res = ($signed(op_i) > $signed(old_i)) ? op_i : old_i;
        ATOP_SMIN: res = ($signed(op_i) < $signed(old_i)) ? op_i : old_i;
        ATOP_UMAX: res = (op_i > old_i) ? op_i : old_i;
        ATOP_UMIN: res = (op_i < old_i) ? op_i : old_i;
        default:   res = old_i;
      endcase
    end
  end

  always_comb begin
    result_o = old_i;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      if (strb_i[b]) result_o[8*b +: 8] = res[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_bank_atomic_adapter.sv
// Per-bank adapter: fixed-latency SRAM macro -> req/gnt/rvalid bank protocol,
// with AXI5 atomics executed locally as read-modify-write.
module mem_bank_atomic_adapter
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned SramLatency = 1,
  parameter int unsigned StrbWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] strb_i,
  input  logic                 we_i,
  input  atop_t                atop_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  if (SramLatency < 1) begin : gen_latency_check
    $fatal(1, "mem_bank_atomic_adapter: SramLatency must be >= 1");
  end

  localparam int unsigned LastIdx = SramLatency - 1;

  typedef struct packed {
    logic valid;
    logic is_amo;
    logic store_only;
  } rsp_entry_t;

  typedef enum logic [1:0] {IDLE, AMO_WAIT, AMO_WRITE} state_e;

  state_e               state_q, state_d;
  rsp_entry_t           rsp_q [SramLatency];
  rsp_entry_t           rsp_d [SramLatency];
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] op_q, op_d;
  logic [StrbWidth-1:0] strb_q, strb_d;
  atop_t                atop_q, atop_d;
  logic [DataWidth-1:0] old_q, old_d;

  logic                 is_amo_req, store_only_req;
  rsp_entry_t           push;
  logic [DataWidth-1:0] alu_result;

  mem_amo_alu #(
    .DataWidth(DataWidth),
    .StrbWidth(StrbWidth)
  ) i_amo_alu (
    .old_i   (old_q),
    .op_i    (op_q),
    .strb_i  (strb_q),
    .atop_i  (atop_q),
    .result_o(alu_result)
  );

  // ATOMICCMP and reserved encodings fall through as plain accesses.
  always_comb begin
    is_amo_req = (atop_i == ATOP_ATOMICSWAP) ||
                 (atop_i[5:4] == ATOP_ATOMICLOAD) ||
                 (atop_i[5:4] == ATOP_ATOMICSTORE);
    store_only_req = is_amo_req ? (atop_i[5:4] == ATOP_ATOMICSTORE) : we_i;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    strb_d       = strb_q;
    atop_d       = atop_q;
    old_d        = old_q;
    push         = '0;
    gnt_o        = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = addr_q;
    sram_wdata_o = '0;
    sram_be_o    = '0;

    unique case (state_q)
      IDLE: begin
        gnt_o        = 1'b1;
        sram_req_o   = req_i;
        sram_addr_o  = addr_i;
        sram_be_o    = strb_i;
        sram_wdata_o = wdata_i;
        sram_we_o    = req_i & we_i & ~is_amo_req;
        if (req_i) begin
          push = '{valid: 1'b1, is_amo: is_amo_req, store_only: store_only_req};
          if (is_amo_req) begin
            addr_d  = addr_i;
            op_d    = wdata_i;
            strb_d  = strb_i;
            atop_d  = atop_i;
            state_d = AMO_WAIT;
          end
        end
      end
      AMO_WAIT: begin
        if (rsp_q[LastIdx].valid && rsp_q[LastIdx].is_amo) begin
          old_d   = sram_rdata_i;
          state_d = AMO_WRITE;
        end
      end
      AMO_WRITE: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_wdata_o = alu_result;
        sram_be_o    = strb_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response pipeline mirrors the SRAM read latency, so responses stay in grant order.
  always_comb begin
    rsp_d[0] = push;
    for (int unsigned i = 1; i < SramLatency; i++) rsp_d[i] = rsp_q[i-1];
  end

  always_comb begin
    rvalid_o = rsp_q[LastIdx].valid;
    rdata_o  = (rsp_q[LastIdx].valid && !rsp_q[LastIdx].store_only) ? sram_rdata_i : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rsp_q   <= '{default: '0};
      addr_q  <= '0;
      op_q    <= '0;
      strb_q  <= '0;
      atop_q  <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      strb_q  <= strb_d;
      atop_q  <= atop_d;
      old_q   <= old_d;
    end
  end

endmodule

// File: tb/tb_mem_bank_atomic_adapter.sv
// Directed bench for mem_bank_atomic_adapter: one instance at SramLatency=1 and
// one at SramLatency=2, each backed by a small behavioural SRAM.
module tb_mem_bank_atomic_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req2, we;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic [5:0]  atop;

  logic        gnt1, rvalid1, s1_req, s1_we;
  logic [31:0] rdata1, s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_be;
  logic        gnt2, rvalid2, s2_req, s2_we;
  logic [31:0] rdata2, s2_addr, s2_wdata, s2_rdata;
  logic [3:0]  s2_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bank_atomic_adapter #(.SramLatency(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .addr_i(addr),
    .wdata_i(wdata), .strb_i(strb), .we_i(we), .atop_i(atop),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .sram_req_o(s1_req), .sram_we_o(s1_we),
    .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata), .sram_be_o(s1_be),
    .sram_rdata_i(s1_rdata)
  );

  mem_bank_atomic_adapter #(.SramLatency(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2), .addr_i(addr),
    .wdata_i(wdata), .strb_i(strb), .we_i(we), .atop_i(atop),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .sram_req_o(s2_req), .sram_we_o(s2_we),
    .sram_addr_o(s2_addr), .sram_wdata_o(s2_wdata), .sram_be_o(s2_be),
    .sram_rdata_i(s2_rdata)
  );

  // Behavioural SRAM macros: 64 words each, reads return after 1 and 2 cycles.
  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];
  logic [31:0] rd2a;
  int          wcnt1 = 0;

  always_ff @(posedge clk) begin
    if (s1_req) begin
      if (s1_we) begin
        for (int b = 0; b < 4; b++)
          if (s1_be[b]) mem1[s1_addr[7:2]][8*b +: 8] <= s1_wdata[8*b +: 8];
        wcnt1 <= wcnt1 + 1;
      end else begin
        s1_rdata <= mem1[s1_addr[7:2]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_req) begin
      if (s2_we) begin
        for (int b = 0; b < 4; b++)
          if (s2_be[b]) mem2[s2_addr[7:2]][8*b +: 8] <= s2_wdata[8*b +: 8];
      end else begin
        rd2a <= mem2[s2_addr[7:2]];
      end
    end
    s2_rdata <= rd2a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle, then let the caller sample.
  task automatic apply(input logic r1, input logic r2, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [5:0] t);
    @(negedge clk);
    req1 = r1; req2 = r2; we = w; addr = a; wdata = d; strb = s; atop = t;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 6'h0);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    apply(1'b1, 1'b0, 1'b1, a, d, 4'hF, 6'h0);
    idle();
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    apply(1'b0, 1'b1, 1'b1, a, d, 4'hF, 6'h0);
    idle();
    idle();
  endtask

  task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
    apply(1'b1, 1'b0, 1'b0, a, 32'h0, 4'hF, 6'h0);
    check({tag, "_gnt"}, 32'(gnt1), 32'h1);
    idle();
    check({tag, "_rvalid"}, 32'(rvalid1), 32'h1);
    check({tag, "_rdata"}, rdata1, exp);
  endtask

  // Full AMO on the latency-1 instance: grant, wait, write-back, back to idle.
  task automatic amo1(input string tag, input logic [5:0] t, input logic [31:0] a,
                      input logic [31:0] op, input logic [3:0] s,
                      input logic [31:0] exp_rdata, input logic [31:0] exp_new);
    apply(1'b1, 1'b0, 1'b1, a, op, s, t);
    check({tag, "_gnt"}, 32'(gnt1), 32'h1);
    check({tag, "_rd_we"}, 32'(s1_we), 32'h0);
    idle();
    check({tag, "_wait_gnt"}, 32'(gnt1), 32'h0);
    check({tag, "_wait_sreq"}, 32'(s1_req), 32'h0);
    check({tag, "_rvalid"}, 32'(rvalid1), 32'h1);
    check({tag, "_rdata"}, rdata1, exp_rdata);
    idle();
    check({tag, "_wr_gnt"}, 32'(gnt1), 32'h0);
    check({tag, "_wr_we"}, 32'(s1_we), 32'h1);
    check({tag, "_wr_be"}, 32'(s1_be), 32'(s));
    check({tag, "_wr_data"}, s1_wdata, exp_new);
    idle();
    check({tag, "_done_gnt"}, 32'(gnt1), 32'h1);
    check({tag, "_done_rvalid"}, 32'(rvalid1), 32'h0);
    check({tag, "_mem"}, mem1[a[7:2]], exp_new);
  endtask

  initial begin
    int wc;
    rst = 1'b1;
    req1 = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0; atop = '0;
    #3;
    check("rst_gnt", 32'(gnt1), 32'h1);
    check("rst_rvalid", 32'(rvalid1), 32'h0);
    check("rst_rdata", rdata1, 32'h0);
    check("rst_sreq", 32'(s1_req), 32'h0);
    check("rst_swe", 32'(s1_we), 32'h0);
    check("rst_saddr", s1_addr, 32'h0);
    check("rst_swdata", s1_wdata, 32'h0);
    check("rst_sbe", 32'(s1_be), 32'h0);
    check("rst2_gnt", 32'(gnt2), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Sequential write then read, latency 1.
    apply(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 6'h0);
    check("wr_gnt", 32'(gnt1), 32'h1);
    check("wr_sreq", 32'(s1_req), 32'h1);
    check("wr_swe", 32'(s1_we), 32'h1);
    apply(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 6'h0);
    check("wr_rvalid", 32'(rvalid1), 32'h1);
    check("wr_rdata", rdata1, 32'h0);
    check("rd_gnt", 32'(gnt1), 32'h1);
    idle();
    check("rd_rvalid", 32'(rvalid1), 32'h1);
    check("rd_rdata", rdata1, 32'hDEADBEEF);
    idle();
    check("rd_rvalid_off", 32'(rvalid1), 32'h0);

    // Atomic add returns old value, then a read sees the sum.
    wr1(32'h20, 32'h5);
    amo1("amo_add", 6'b100000, 32'h20, 32'h3, 4'hF, 32'h5, 32'h8);
    rd1("amo_add_rb", 32'h20, 32'h8);

    // Signed / unsigned bounds and wrap.
    wr1(32'h30, 32'hFFFFFFFF);
    amo1("smax", 6'b010100, 32'h30, 32'h1, 4'hF, 32'h0, 32'h1);
    wr1(32'h30, 32'hFFFFFFFF);
    amo1("umax", 6'b010110, 32'h30, 32'h1, 4'hF, 32'h0, 32'hFFFFFFFF);
    amo1("add_wrap", 6'b100000, 32'h30, 32'h1, 4'hF, 32'hFFFFFFFF, 32'h0);

    // Partial-strobe swap keeps the masked-off bytes.
    wr1(32'h34, 32'h11223344);
    amo1("swap_part", 6'b110000, 32'h34, 32'hAABBCCDD, 4'b0011, 32'h11223344, 32'h1122CCDD);

    // Remaining logic ops and min variants.
    wr1(32'h38, 32'hFF00FF00);
    amo1("clr", 6'b100001, 32'h38, 32'h0F0F0F0F, 4'hF, 32'hFF00FF00, 32'hF000F000);
    wr1(32'h38, 32'hFFFF0000);
    amo1("eor", 6'b010010, 32'h38, 32'h0F0F0F0F, 4'hF, 32'h0, 32'hF0F00F0F);
    wr1(32'h38, 32'h00000011);
    amo1("set", 6'b100011, 32'h38, 32'h00001100, 4'hF, 32'h00000011, 32'h00001111);
    wr1(32'h3C, 32'h7FFFFFFF);
    amo1("smin", 6'b100101, 32'h3C, 32'h80000000, 4'hF, 32'h7FFFFFFF, 32'h80000000);
    wr1(32'h3C, 32'h7FFFFFFF);
    amo1("umin", 6'b010111, 32'h3C, 32'h80000000, 4'hF, 32'h0, 32'h7FFFFFFF);
    amo1("smax_eq", 6'b100100, 32'h3C, 32'h7FFFFFFF, 4'hF, 32'h7FFFFFFF, 32'h7FFFFFFF);

    // ATOMICCMP degrades to a plain write.
    apply(1'b1, 1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 6'b110001);
    check("cmp_gnt", 32'(gnt1), 32'h1);
    check("cmp_swe", 32'(s1_we), 32'h1);
    idle();
    check("cmp_rvalid", 32'(rvalid1), 32'h1);
    check("cmp_rdata", rdata1, 32'h0);
    check("cmp_gnt_after", 32'(gnt1), 32'h1);
    rd1("cmp_rb", 32'h50, 32'hCAFEF00D);

    // Reset during AMO_WAIT drops the pending write and its response.
    wr1(32'h40, 32'h1234);
    idle();
    apply(1'b1, 1'b0, 1'b1, 32'h40, 32'h1, 4'hF, 6'b100000);
    wc = wcnt1;
    @(negedge clk);
    rst = 1'b1; req1 = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0; atop = '0;
    #1;
    check("mid_rst_gnt", 32'(gnt1), 32'h1);
    check("mid_rst_rvalid", 32'(rvalid1), 32'h0);
    check("mid_rst_rdata", rdata1, 32'h0);
    check("mid_rst_swe", 32'(s1_we), 32'h0);
    check("mid_rst_sreq", 32'(s1_req), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_nowrite", 32'(wcnt1 - wc), 32'h0);
    check("mid_rst_mem", mem1[6'h10], 32'h1234);
    check("mid_rst_gnt_rel", 32'(gnt1), 32'h1);
    idle();
    check("mid_rst_rvalid_rel", 32'(rvalid1), 32'h0);
    rd1("mid_rst_rb", 32'h40, 32'h1234);

    // Back-to-back reads, latency 2.
    wr2(32'h0, 32'hA0A0A0A0);
    wr2(32'h4, 32'hA1A1A1A1);
    wr2(32'h8, 32'hA2A2A2A2);
    idle();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 6'h0);
    check("b2b_gnt0", 32'(gnt2), 32'h1);
    check("b2b_rv0", 32'(rvalid2), 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 6'h0);
    check("b2b_gnt1", 32'(gnt2), 32'h1);
    check("b2b_rv1", 32'(rvalid2), 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 6'h0);
    check("b2b_gnt2", 32'(gnt2), 32'h1);
    check("b2b_rv2", 32'(rvalid2), 32'h1);
    check("b2b_d0", rdata2, 32'hA0A0A0A0);
    idle();
    check("b2b_rv3", 32'(rvalid2), 32'h1);
    check("b2b_d1", rdata2, 32'hA1A1A1A1);
    idle();
    check("b2b_rv4", 32'(rvalid2), 32'h1);
    check("b2b_d2", rdata2, 32'hA2A2A2A2);
    idle();
    check("b2b_rv5", 32'(rvalid2), 32'h0);

    // AMO at latency 2 holds gnt low for three cycles.
    wr2(32'hC, 32'd10);
    apply(1'b0, 1'b1, 1'b1, 32'hC, 32'h1, 4'hF, 6'b100000);
    check("l2_amo_gnt", 32'(gnt2), 32'h1);
    idle();
    check("l2_amo_w1_gnt", 32'(gnt2), 32'h0);
    check("l2_amo_w1_rv", 32'(rvalid2), 32'h0);
    idle();
    check("l2_amo_w2_gnt", 32'(gnt2), 32'h0);
    check("l2_amo_rv", 32'(rvalid2), 32'h1);
    check("l2_amo_rdata", rdata2, 32'd10);
    idle();
    check("l2_amo_wr_gnt", 32'(gnt2), 32'h0);
    check("l2_amo_wr_we", 32'(s2_we), 32'h1);
    check("l2_amo_wr_data", s2_wdata, 32'd11);
    idle();
    check("l2_amo_done_gnt", 32'(gnt2), 32'h1);
    check("l2_amo_mem", mem2[3], 32'd11);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bank_atomic_adapter.md
Name: mem_bank_atomic_adapter

Overview:
- Per-bank stage placed directly downstream of each bank port of the interleaved AXI-to-memory converter.
- Turns a fixed-latency, always-ready SRAM macro (no grant, no valid) into the req/gnt/rvalid bank protocol that the converter expects.
- Executes AXI5 atomics (ATOP) locally as read-modify-write and returns the old value.
- One instance per bank; the bank ports connect 1:1.

Parameters:
- AddrWidth, 32, byte-address width of addr_i and sram_addr_o.
- DataWidth, 32, bank word width. Multiple of 8.
- SramLatency, 1, fixed SRAM read latency in cycles. Must be >= 1; elaboration-time fatal otherwise.
- StrbWidth, DataWidth/8, dependent, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid from upstream.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  AddrWidth  byte address.
- wdata_i  in  DataWidth  write data / AMO operand.
- strb_i  in  StrbWidth  byte enables.
- we_i  in  1  write enable.
- atop_i  in  6  axi_pkg::atop_t.
- rvalid_o  out  1  response valid, one per granted request.
- rdata_o  out  DataWidth  read data or AMO old value.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address, passed through unchanged.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  StrbWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid SramLatency cycles after a read.

Behaviour:
- Reset: FSM = IDLE, response shift register cleared, operand and old-value registers cleared.
- Reset values of outputs: gnt_o=1, rvalid_o=0, rdata_o=0, all sram_* outputs=0.
- Reset mid-AMO: the pending write is dropped and no rvalid is produced.

FSM states:
- IDLE:
  - gnt_o=1. Upstream has no ready, so a response is never stalled.
  - Plain access (atop_i[5:4]==ATOP_NONE, or ATOMICCMP, which is unsupported and executed as a plain write when we_i=1): drive SRAM combinationally from the inputs (sram_req_o = req_i, sram_be_o = strb_i). Stay in IDLE.
  - AMO (ATOMICSWAP, ATOMICLOAD, or ATOMICSTORE):
    - Issue an SRAM read to addr_i.
    - Latch addr_i, wdata_i, strb_i and atop_i.
    - Go to AMO_WAIT.
- AMO_WAIT:
  - gnt_o=0, sram_req_o=0.
  - Stay until the AMO read beat exits the shift register (SramLatency cycles after grant).
  - In that cycle, capture sram_rdata_i into the old-value register and go to AMO_WRITE.
- AMO_WRITE:
  - gnt_o=0.
  - Write the ALU result with sram_we_o=1 and sram_be_o = latched strb.
  - Go to IDLE. The next request can be granted the following cycle.

Responses:
- Shift register of depth SramLatency.
- Each granted request pushes {valid, is_amo, is_store_only}.
- rvalid_o is asserted exactly SramLatency cycles after the grant cycle, for reads, writes and AMOs alike.
- rdata_o:
  - = sram_rdata_i for reads and for ATOMICLOAD/ATOMICSWAP (old value).
  - = 0 for plain writes and ATOMICSTORE.
- The AMO write itself pushes no entry. Responses stay in grant order.

ALU (full DataWidth arithmetic, old = memory value, op = operand):
- Operation per atop_i[2:0]:
  - ADD: old + op, wrap mod 2^DataWidth.
  - CLR: old & ~op.
  - EOR: old ^ op.
  - SET: old | op.
  - SMAX / SMIN: signed on bit DataWidth-1.
  - UMAX / UMIN: unsigned.
- SWAP result = op.
- Bytes with strb=0 retain old.
- Equal operands: MAX/MIN return old.

Throughput:
- Plain accesses: 1 per cycle.
- Each AMO occupies SramLatency+1 cycles.
- A read granted right after AMO_WRITE returns the updated value.

Decomposition:
- Atop encodings come from axi_pkg (ATOP_NONE, ATOP_ATOMICSWAP, ATOP_ATOMICCMP, ATOP_ATOMICLOAD, ATOP_ATOMICSTORE, ATOP_ADD … ATOP_UMIN). No new package.
- Local typedef: rsp_entry_t {valid, is_amo, store_only}.
- One natural sub-module: mem_amo_alu, purely combinational (old, op, strb, atop) -> result, reusable by other bank adapters.

Test Plan:
- Sequential write/read: write 0xDEADBEEF, strb 4'hF to 0x10, then read 0x10 (SramLatency=1) -> rvalid one cycle after each grant; read returns 0xDEADBEEF; write response rdata=0.
- Back-to-back reads: reads to 0x0, 0x4, 0x8 on three consecutive cycles, SramLatency=2 -> gnt_o held 1; three rvalids on consecutive cycles, starting 2 cycles after the first grant, in order.
- Atomic add: mem[0x20]=0x00000005; ATOMICLOAD ADD op 0x3 -> rvalid data 0x5; gnt_o low for 2 cycles; subsequent read returns 0x8.
- Signed/unsigned bounds: mem=0xFFFFFFFF; SMAX op 0x1 -> stored 0x1. Repeat with UMAX op 0x1 -> stored 0xFFFFFFFF. ADD 0x1 on 0xFFFFFFFF -> wraps to 0x0.
- Partial strobe: mem=0x11223344; ATOMICSWAP op 0xAABBCCDD, strb 4'b0011 -> returns 0x11223344; memory = 0x1122CCDD.
- Reset mid-AMO: assert rst_i during AMO_WAIT -> all outputs at reset values; no rvalid; no SRAM write; gnt_o=1 after release.
